alu_checker: RTL and testbench

ALU_CHECKER -- requirements
Module: alu_checker

---
 rtl/alu_checker.sv | 167 ++++++++++++++++
 tb/tb_alu_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_checker.sv
// Scoreboard checker for a 32-bit ALU: captures a transaction, recomputes the
// expected result/status, compares, and keeps pass/fail statistics.
module alu_checker #(
   parameter int unsigned STOP_ON_FAIL = 0,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [2:0]       sel,
   input  logic             cin,
   input  logic [31:0]      out,
   input  logic [3:0]       stat,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             err,
   output logic [2:0]       first_fail_sel,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic             halted
);

   typedef enum logic [1:0] {
      IDLE,
      CAPT,
      CMP,
      HALT
   } state_t;

   state_t           state_q;
   logic             ready_q;
   logic             halted_q;
   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] fail_q;
   logic [CNT_W-1:0] idx_q;
   logic             err_q;
   logic [2:0]       ffsel_q;
   logic [CNT_W-1:0] ffidx_q;

   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic [2:0]       sel_q;
   logic             cin_q;
   logic [31:0]      out_q;
   logic [3:0]       stat_q;
   logic [31:0]      exp_out_q;
   logic [3:0]       exp_stat_q;

   logic             accept;
   logic             mismatch;
   logic [32:0]      arith_d;
   logic [31:0]      exp_out_d;
   logic [3:0]       exp_stat_d;
   logic             c_d;
   logic             v_d;

   assign accept   = in_valid && ready_q;
   assign mismatch = (out_q != exp_out_q) || (stat_q != exp_stat_q);

   // Reference model: sign-extended 33-bit arithmetic gives overflow as
   // bit32^bit31; the unsigned carry/borrow out is recovered as bit32^a31^b31.
   always_comb begin
      arith_d   = '0;
      exp_out_d = '0;
      c_d       = 1'b0;
      v_d       = 1'b0;
      case (sel_q)
         3'b000: begin
            arith_d   = {a_q[31], a_q} + {b_q[31], b_q} + {32'd0, cin_q};
            exp_out_d = arith_d[31:0];
            c_d       = arith_d[32] ^ a_q[31] ^ b_q[31];
            v_d       = arith_d[32] ^ arith_d[31];
         end
         3'b001: begin
            arith_d   = {a_q[31], a_q} - {b_q[31], b_q} - {32'd0, cin_q};
            exp_out_d = arith_d[31:0];
            c_d       = ~(arith_d[32] ^ a_q[31] ^ b_q[31]);
            v_d       = arith_d[32] ^ arith_d[31];
         end
         3'b010:  exp_out_d = a_q & b_q;
         3'b011:  exp_out_d = a_q | b_q;
         3'b100:  exp_out_d = a_q ^ b_q;
         3'b101:  exp_out_d = ~a_q;
         3'b110:  exp_out_d = a_q << b_q[4:0];
         default: exp_out_d = a_q >> b_q[4:0];
      endcase
      exp_stat_d = {v_d, c_d, exp_out_d[31], (exp_out_d == 32'd0)};
   end

   always_ff @(posedge clk) begin
      if (state_q == IDLE && accept) begin
         a_q    <= a;
         b_q    <= b;
         sel_q  <= sel;
         cin_q  <= cin;
         out_q  <= out;
         stat_q <= stat;
      end
      if (state_q == CAPT) begin
         exp_out_q  <= exp_out_d;
         exp_stat_q <= exp_stat_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q  <= IDLE;
         ready_q  <= 1'b1;
         halted_q <= 1'b0;
         pass_q   <= '0;
         fail_q   <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
         ffsel_q  <= '0;
         ffidx_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= CAPT;
                  ready_q <= 1'b0;
               end
            end
            CAPT: begin
               state_q <= CMP;
            end
            CMP: begin
               idx_q <= idx_q + CNT_W'(1);
               if (!mismatch) begin
                  if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end else begin
                  if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
                  if (!err_q) begin
                     err_q   <= 1'b1;
                     ffsel_q <= sel_q;
                     ffidx_q <= idx_q;
                  end
                  if (STOP_ON_FAIL != 0) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= HALT;
            end
         endcase
      end
   end

   assign in_ready       = ready_q;
   assign halted         = halted_q;
   assign pass_count     = pass_q;
   assign fail_count     = fail_q;
   assign err            = err_q;
   assign first_fail_sel = ffsel_q;
   assign first_fail_idx = ffidx_q;

endmodule

// File: tb/tb_alu_checker.sv
// Bench for alu_checker: three instances (default, stop-on-fail, 2-bit counters)
// fed directed vectors; expected counter states are queued and checked on completion.
module tb_alu_checker;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic [2:0]  v     = '0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic [31:0] out   = '0;
   logic [2:0]  sel   = '0;
   logic        cin   = 1'b0;
   logic [3:0]  stat  = '0;

   logic [2:0]  rdy;
   logic [2:0]  halt;
   logic [2:0]  errv;
   logic [15:0] pc0, fc0, fi0, pc1, fc1, fi1;
   logic [1:0]  pc2, fc2, fi2;
   logic [2:0]  fs0, fs1, fs2;

   always #5 clk = ~clk;

   alu_checker u0 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(v[0]), .in_ready(rdy[0]),
      .a(a), .b(b), .sel(sel), .cin(cin), .out(out), .stat(stat),
      .pass_count(pc0), .fail_count(fc0), .err(errv[0]),
      .first_fail_sel(fs0), .first_fail_idx(fi0), .halted(halt[0])
   );

   alu_checker #(.STOP_ON_FAIL(1)) u1 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(v[1]), .in_ready(rdy[1]),
      .a(a), .b(b), .sel(sel), .cin(cin), .out(out), .stat(stat),
      .pass_count(pc1), .fail_count(fc1), .err(errv[1]),
      .first_fail_sel(fs1), .first_fail_idx(fi1), .halted(halt[1])
   );

   alu_checker #(.CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(v[2]), .in_ready(rdy[2]),
      .a(a), .b(b), .sel(sel), .cin(cin), .out(out), .stat(stat),
      .pass_count(pc2), .fail_count(fc2), .err(errv[2]),
      .first_fail_sel(fs2), .first_fail_idx(fi2), .halted(halt[2])
   );

   typedef struct {
      int          tag;
      logic [15:0] pc;
      logic [15:0] fc;
      logic        e;
      logic [2:0]  fs;
      logic [15:0] fi;
   } resp_t;

   resp_t q[$];
   int    tests = 0;
   int    fails = 0;

   function automatic resp_t mk(int t, int p, int f, bit e, int s, int i);
      resp_t r;
      r.tag = t;
      r.pc  = 16'(p);
      r.fc  = 16'(f);
      r.e   = e;
      r.fs  = 3'(s);
      r.fi  = 16'(i);
      return r;
   endfunction

   function automatic resp_t actual(int i);
      resp_t r;
      r = mk(i, 0, 0, 1'b0, 0, 0);
      case (i)
         0: begin r.pc = pc0; r.fc = fc0; r.e = errv[0]; r.fs = fs0; r.fi = fi0; end
         1: begin r.pc = pc1; r.fc = fc1; r.e = errv[1]; r.fs = fs1; r.fi = fi1; end
         default: begin
            r.pc = {14'd0, pc2}; r.fc = {14'd0, fc2}; r.e = errv[2];
            r.fs = fs2; r.fi = {14'd0, fi2};
         end
      endcase
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
      end
   endtask

   task automatic cmp_resp(string pfx, resp_t got, resp_t want);
      chk($sformatf("%s.pass_count", pfx), 32'(got.pc), 32'(want.pc));
      chk($sformatf("%s.fail_count", pfx), 32'(got.fc), 32'(want.fc));
      chk($sformatf("%s.err", pfx), 32'(got.e), 32'(want.e));
      chk($sformatf("%s.first_fail_sel", pfx), 32'(got.fs), 32'(want.fs));
      chk($sformatf("%s.first_fail_idx", pfx), 32'(got.fi), 32'(want.fi));
   endtask

   // A response is in_ready rising (CMP->IDLE) or halted rising, not caused by reset/clear.
   task automatic monitor();
      logic [2:0] prev_rdy  = '1;
      logic [2:0] prev_halt = '0;
      int         busy [3]  = '{0, 0, 0};
      logic       rst_seen;
      resp_t      exp_r;
      forever begin
         @(posedge clk);
         rst_seen = reset | clear;
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (rdy[i] !== 1'b1) busy[i]++;
            if (!rst_seen && ((rdy[i] === 1'b1 && prev_rdy[i] !== 1'b1) ||
                              (halt[i] === 1'b1 && prev_halt[i] !== 1'b1))) begin
               if (q.size() == 0 || q[0].tag != i) begin
                  tests++;
                  fails++;
                  $display("FAIL u%0d.unexpected_response: got a response, expected none", i);
               end else begin
                  exp_r = q.pop_front();
                  cmp_resp($sformatf("u%0d", i), actual(i), exp_r);
                  if (rdy[i] === 1'b1)
                     chk($sformatf("u%0d.busy_cycles", i), 32'(busy[i]), 32'd2);
               end
            end
            if (rdy[i] === 1'b1) busy[i] = 0;
            prev_rdy[i]  = rdy[i];
            prev_halt[i] = halt[i];
         end
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(int t, logic [2:0] s, logic [31:0] aa, logic [31:0] bb, logic ci,
                       logic [31:0] o, logic [3:0] st, bit push, resp_t e);
      int n = 0;
      sel = s; a = aa; b = bb; cin = ci; out = o; stat = st;
      v[t] = 1'b1;
      while (rdy[t] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         tests++;
         fails++;
         $display("FAIL u%0d.accept_timeout: in_ready stayed 0, expected 1", t);
         v[t] = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) q.push_back(e);
      @(negedge clk);
      v[t] = 1'b0;
   endtask

   initial begin
      int n;
      fork
         monitor();
      join_none

      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cmp_resp($sformatf("reset.u%0d", i), actual(i), mk(i, 0, 0, 1'b0, 0, 0));
         chk($sformatf("reset.u%0d.in_ready", i), 32'(rdy[i]), 32'd1);
         chk($sformatf("reset.u%0d.halted", i), 32'(halt[i]), 32'd0);
      end

      send(0, 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0101, 1'b1, mk(0, 1, 0, 0, 0, 0));
      repeat (2) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      cmp_resp("clear.u0", actual(0), mk(0, 0, 0, 0, 0, 0));

      send(0, 3'b001, 32'h3, 32'h5, 1'b0, 32'hFFFF_FFFE, 4'b0010, 1'b1, mk(0, 1, 0, 0, 0, 0));
      send(0, 3'b100, 32'h3333_3333, 32'h5555_5555, 1'b0, 32'h6666_6666, 4'b0001, 1'b1,
           mk(0, 1, 1, 1, 4, 1));
      send(0, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F001, 4'b0010, 1'b1,
           mk(0, 1, 2, 1, 4, 1));
      send(0, 3'b011, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0001, 1'b1, mk(0, 2, 2, 1, 4, 1));
      send(0, 3'b101, 32'h0000_FFFF, 32'h1234_5678, 1'b0, 32'hFFFF_0000, 4'b0010, 1'b1,
           mk(0, 3, 2, 1, 4, 1));
      send(0, 3'b110, 32'h1, 32'h3F, 1'b0, 32'h8000_0000, 4'b0010, 1'b1, mk(0, 4, 2, 1, 4, 1));
      send(0, 3'b111, 32'h8000_0000, 32'h24, 1'b0, 32'h0800_0000, 4'b0000, 1'b1,
           mk(0, 5, 2, 1, 4, 1));
      send(0, 3'b000, 32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 4'b1010, 1'b1,
           mk(0, 6, 2, 1, 4, 1));
      send(0, 3'b001, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 4'b1100, 1'b1,
           mk(0, 7, 2, 1, 4, 1));
      send(0, 3'b001, 32'h5, 32'h2, 1'b1, 32'h2, 4'b0100, 1'b1, mk(0, 8, 2, 1, 4, 1));
      send(0, 3'b000, 32'h1, 32'h1, 1'b1, 32'h3, 4'b0100, 1'b1, mk(0, 8, 3, 1, 4, 1));

      // Mismatching transaction aborted by reset while in CAPT.
      send(0, 3'b100, 32'h1, 32'h1, 1'b0, 32'hFFFF_FFFF, 4'b0000, 1'b0, mk(0, 0, 0, 0, 0, 0));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cmp_resp("abort.u0", actual(0), mk(0, 0, 0, 0, 0, 0));
      chk("abort.u0.in_ready", 32'(rdy[0]), 32'd1);
      repeat (3) @(negedge clk);
      chk("abort.u0.fail_count_late", 32'(fc0), 32'd0);

      send(1, 3'b000, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b0101, 1'b1, mk(1, 1, 0, 0, 0, 0));
      send(1, 3'b100, 32'h3333_3333, 32'h5555_5555, 1'b0, 32'h6666_6666, 4'b0001, 1'b1,
           mk(1, 1, 1, 1, 4, 1));
      repeat (2) @(negedge clk);
      sel = 3'b000; a = 32'h1; b = 32'h1; cin = 1'b0; out = 32'h2; stat = 4'b0000;
      v[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("halt.u1.halted", 32'(halt[1]), 32'd1);
         chk("halt.u1.in_ready", 32'(rdy[1]), 32'd0);
      end
      v[1] = 1'b0;
      cmp_resp("halt.u1", actual(1), mk(1, 1, 1, 1, 4, 1));
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      cmp_resp("unhalt.u1", actual(1), mk(1, 0, 0, 0, 0, 0));
      chk("unhalt.u1.in_ready", 32'(rdy[1]), 32'd1);
      chk("unhalt.u1.halted", 32'(halt[1]), 32'd0);
      send(1, 3'b000, 32'h1, 32'h1, 1'b0, 32'h2, 4'b0000, 1'b1, mk(1, 1, 0, 0, 0, 0));
      repeat (3) @(negedge clk);

      for (int k = 0; k < 5; k++)
         send(2, 3'b000, 32'h1, 32'h1, 1'b0, 32'h2, 4'b0000, 1'b1,
              mk(2, (k < 2) ? k + 1 : 3, 0, 0, 0, 0));
      send(2, 3'b000, 32'h1, 32'h1, 1'b0, 32'h3, 4'b0000, 1'b1, mk(2, 3, 1, 1, 0, 1));

      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d responses outstanding, expected 0", q.size());
      end
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
